// File: rtl/blk_rom_arbiter.sv
// Round-robin burst arbiter in front of a single-port block ROM with 1-cycle read latency.
// Grants one requester at a time and streams its burst at one word per cycle.
module blk_rom_arbiter #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 12,
  parameter int DataWidth = 9,
  parameter int LenWidth  = 4
) (
  input  logic                          clka,
  input  logic                          reset,
  input  logic [NumReq-1:0]             req_valid,
  input  logic [NumReq*AddrWidth-1:0]   req_addr,
  input  logic [NumReq*LenWidth-1:0]    req_len,
  output logic [NumReq-1:0]             req_ready,
  output logic                          rom_ena,
  output logic [AddrWidth-1:0]          rom_addra,
  input  logic [DataWidth-1:0]          rom_douta,
  output logic                          rsp_valid,
  output logic [$clog2(NumReq)-1:0]     rsp_id,
  output logic                          rsp_last,
  output logic [DataWidth-1:0]          rsp_data
);

  localparam int IdW = $clog2(NumReq);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [IdW-1:0]        rr_ptr;
  logic [IdW-1:0]        owner;
  logic [AddrWidth-1:0]  next_addr;
  logic [LenWidth-1:0]   remaining;

  logic                  grant_any;
  logic [IdW-1:0]        grant_idx;
  logic [AddrWidth-1:0]  start_addr;
  logic [LenWidth-1:0]   start_left;
  logic [IdW-1:0]        issue_id;
  logic                  issue_last;

  logic                  rsp_valid_q;
  logic [IdW-1:0]        rsp_id_q;
  logic                  rsp_last_q;

  logic [AddrWidth-1:0]  addr_arr [NumReq];
  logic [LenWidth-1:0]   len_arr  [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AddrWidth +: AddrWidth];
    assign len_arr[i]  = req_len[i*LenWidth +: LenWidth];
  end

  // Scan from rr_ptr upward with wrap; iterating downward lets the nearest candidate win.
  always_comb begin : grant_search
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (req_valid[cand[IdW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IdW-1:0];
      end
    end
  end

  // A length field of zero wraps to all-ones here, i.e. 2^LenWidth beats in total.
  assign start_addr = addr_arr[grant_idx];
  assign start_left = len_arr[grant_idx] - LenWidth'(1);

  always_comb begin
    req_ready  = '0;
    rom_ena    = 1'b0;
    rom_addra  = '0;
    issue_id   = owner;
    issue_last = 1'b0;
    if (!reset) begin
      if (state == BURST) begin
        rom_ena    = 1'b1;
        rom_addra  = next_addr;
        issue_last = (remaining == LenWidth'(1));
      end else if (grant_any) begin
        rom_ena              = 1'b1;
        rom_addra            = start_addr;
        req_ready[grant_idx] = 1'b1;
        issue_id             = grant_idx;
        issue_last           = (start_left == '0);
      end
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner     <= grant_idx;
            next_addr <= start_addr + AddrWidth'(1);
            remaining <= start_left;
            rr_ptr    <= (grant_idx == IdW'(NumReq - 1)) ? '0 : grant_idx + IdW'(1);
            if (start_left != '0) state <= BURST;
          end
        end
        BURST: begin
          next_addr <= next_addr + AddrWidth'(1);
          remaining <= remaining - LenWidth'(1);
          if (remaining == LenWidth'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response tags trail the ROM read by one cycle to line up with rom_douta.
  always_ff @(posedge clka) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rom_ena;
      rsp_id_q    <= issue_id;
      rsp_last_q  <= issue_last;
    end
  end

  assign rsp_valid = rsp_valid_q & ~reset;
  assign rsp_id    = reset ? '0 : rsp_id_q;
  assign rsp_last  = rsp_last_q & ~reset;
  assign rsp_data  = rom_douta;

endmodule

// File: tb/tb_blk_rom_arbiter.sv
// Self-checking bench for blk_rom_arbiter: directed vectors, corner-case sequences and
// randomized traffic checked every cycle against a transaction-level model.
module tb_blk_rom_arbiter;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] addr_a [4];
  logic [3:0]  len_a  [4];
  logic [47:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  req_ready;
  logic        rom_ena;
  logic [11:0] rom_addra;
  logic [8:0]  rom_douta;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_last;
  logic [8:0]  rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_addr[i*12 +: 12] = addr_a[i];
    assign req_len[i*4 +: 4]    = len_a[i];
  end

  blk_rom_arbiter #(.NumReq(4), .AddrWidth(12), .DataWidth(9), .LenWidth(4)) dut (
    .clka(clka), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(req_ready), .rom_ena(rom_ena), .rom_addra(rom_addra),
    .rom_douta(rom_douta), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .rsp_data(rsp_data)
  );

  function automatic logic [8:0] romWord(input logic [11:0] a);
    return 9'((int'(a) * 13 + 7) ^ (int'(a) >> 4));
  endfunction

  always @(posedge clka) if (rom_ena) rom_douta <= romWord(rom_addra);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [11:0] a, input logic [3:0] l);
    addr_a[idx]    = a;
    len_a[idx]     = l;
    req_valid[idx] = v;
  endtask

  task automatic waitCycle();
    @(posedge clka);
    #1;
  endtask

  // Transaction-level model: one active burst described by owner, next address and beats left.
  bit m_busy = 0;
  int m_owner = 0, m_left = 0, m_addr = 0, m_ptr = 0;
  bit p_valid = 0, p_last = 0;
  int p_id = 0, p_addr = 0;

  always @(negedge clka) begin
    logic [3:0] e_ready;
    bit iss, is_last;
    int iss_id, e_addr, g, idx, blen;
    e_ready = '0; iss = 0; is_last = 0; iss_id = 0; e_addr = 0; g = -1; blen = 0;
    if (reset) begin
      checkOutput("m_ready_rst", req_ready, 0);
      checkOutput("m_ena_rst", rom_ena, 0);
      checkOutput("m_addr_rst", rom_addra, 0);
      checkOutput("m_rspv_rst", rsp_valid, 0);
      checkOutput("m_rspid_rst", rsp_id, 0);
      checkOutput("m_rspl_rst", rsp_last, 0);
      m_busy = 0; m_ptr = 0; p_valid = 0; p_last = 0;
    end else begin
      checkOutput("m_rsp_valid", rsp_valid, p_valid);
      checkOutput("m_rsp_last", rsp_last, p_valid & p_last);
      if (p_valid) begin
        checkOutput("m_rsp_id", rsp_id, p_id);
        checkOutput("m_rsp_data", rsp_data, romWord(12'(p_addr)));
      end
      if (m_busy) begin
        iss = 1; iss_id = m_owner; e_addr = m_addr; is_last = (m_left == 1);
        m_addr = (m_addr + 1) % 4096;
        m_left--;
        m_busy = (m_left > 0);
      end else begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (g < 0 && req_valid[2'(idx)]) g = idx;
        end
        if (g >= 0) begin
          blen = (len_a[2'(g)] == 0) ? 16 : int'(len_a[2'(g)]);
          iss = 1; iss_id = g; e_addr = int'(addr_a[2'(g)]); is_last = (blen == 1);
          e_ready[2'(g)] = 1'b1;
          m_owner = g; m_addr = (e_addr + 1) % 4096; m_left = blen - 1;
          m_busy = (blen > 1); m_ptr = (g + 1) % 4;
        end
      end
      checkOutput("m_req_ready", req_ready, e_ready);
      checkOutput("m_rom_ena", rom_ena, iss);
      checkOutput("m_rom_addra", rom_addra, e_addr);
      p_valid = iss; p_id = iss_id; p_last = is_last; p_addr = e_addr;
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [11:0] addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats, lasts, last_at;
    bit no_gap, saw1;
    logic [3:0] rdy;

    // Each row is one cycle with every requester asking for one word; rr pointer starts at 0.
    vecs[0] = '{4'b1111, 4'b0001, 12'h100};
    vecs[1] = '{4'b1111, 4'b0010, 12'h200};
    vecs[2] = '{4'b1001, 4'b1000, 12'h400};
    vecs[3] = '{4'b0110, 4'b0010, 12'h200};
    vecs[4] = '{4'b0000, 4'b0000, 12'h000};
    vecs[5] = '{4'b0011, 4'b0001, 12'h100};
    vecs[6] = '{4'b0001, 4'b0001, 12'h100};
    vecs[7] = '{4'b0100, 4'b0100, 12'h300};
    vecs[8] = '{4'b1000, 4'b1000, 12'h400};

    for (int i = 0; i < 4; i++) begin
      addr_a[i] = '0;
      len_a[i]  = '0;
    end
    reset = 1'b1;
    repeat (3) waitCycle();
    reset = 1'b0;

    // Single burst of three words from requester 2.
    applyStimulus(2, 1'b1, 12'h010, 4'd3);
    @(negedge clka);
    checkOutput("single_ready", req_ready, 4'b0100);
    checkOutput("single_addr0", rom_addra, 12'h010);
    waitCycle();
    req_valid[2] = 1'b0;
    @(negedge clka);
    checkOutput("single_addr1", rom_addra, 12'h011);
    checkOutput("single_rsp_id", rsp_id, 2);
    checkOutput("single_last0", rsp_last, 0);
    waitCycle();
    @(negedge clka);
    checkOutput("single_addr2", rom_addra, 12'h012);
    checkOutput("single_last1", rsp_last, 0);
    waitCycle();
    @(negedge clka);
    checkOutput("single_rsp_v3", rsp_valid, 1);
    checkOutput("single_last2", rsp_last, 1);
    checkOutput("single_ena_off", rom_ena, 0);
    waitCycle();

    // Length 0 means 16 words, and the address wraps past 0xFFF.
    applyStimulus(1, 1'b1, 12'hFFE, 4'd0);
    beats = 0; lasts = 0; last_at = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clka);
      if (i == 0) checkOutput("wrap_ready", req_ready, 4'b0010);
      if (i == 2) checkOutput("wrap_addr", rom_addra, 12'h000);
      if (rsp_valid) beats++;
      if (rsp_last) begin
        lasts++;
        last_at = i;
      end
      waitCycle();
      if (i == 0) req_valid[1] = 1'b0;
    end
    checkOutput("wrap_beats", beats, 16);
    checkOutput("wrap_lasts", lasts, 1);
    checkOutput("wrap_last_at", last_at, 16);

    // A request arriving mid-burst waits and follows with no idle ROM cycle.
    applyStimulus(0, 1'b1, 12'h200, 4'd8);
    @(negedge clka);
    checkOutput("np_ready0", req_ready, 4'b0001);
    waitCycle();
    req_valid[0] = 1'b0;
    applyStimulus(3, 1'b1, 12'h300, 4'd2);
    no_gap = 1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clka);
      if (t < 8 && (!rom_ena || req_ready != 4'b0000)) no_gap = 0;
      if (t == 8) begin
        checkOutput("np_ready3", req_ready, 4'b1000);
        checkOutput("np_addr3", rom_addra, 12'h300);
      end
      waitCycle();
    end
    req_valid[3] = 1'b0;
    checkOutput("np_no_gap", no_gap, 1);
    @(negedge clka);
    checkOutput("np_rsp_valid", rsp_valid, 1);
    checkOutput("np_rsp_id", rsp_id, 3);
    repeat (3) waitCycle();

    // Reset in the middle of a burst abandons it and returns the pointer to 0.
    applyStimulus(0, 1'b1, 12'h050, 4'd10);
    @(negedge clka);
    checkOutput("rst_ready0", req_ready, 4'b0001);
    waitCycle();
    req_valid[0] = 1'b0;
    repeat (3) waitCycle();
    reset = 1'b1;
    @(negedge clka);
    checkOutput("rst_ena_during", rom_ena, 0);
    waitCycle();
    reset = 1'b0;
    @(negedge clka);
    checkOutput("rst_after_ena", rom_ena, 0);
    checkOutput("rst_after_addr", rom_addra, 0);
    checkOutput("rst_after_rspv", rsp_valid, 0);
    checkOutput("rst_after_ready", req_ready, 0);
    waitCycle();
    applyStimulus(0, 1'b1, 12'h060, 4'd1);
    applyStimulus(3, 1'b1, 12'h070, 4'd1);
    @(negedge clka);
    checkOutput("rst_regrant", req_ready, 4'b0001);
    waitCycle();
    req_valid[0] = 1'b0;
    @(negedge clka);
    checkOutput("rst_regrant3", req_ready, 4'b1000);
    waitCycle();
    req_valid[3] = 1'b0;
    waitCycle();

    // A request withdrawn during someone else's burst is never granted.
    applyStimulus(0, 1'b1, 12'h080, 4'd5);
    @(negedge clka);
    waitCycle();
    req_valid[0] = 1'b0;
    applyStimulus(1, 1'b1, 12'h090, 4'd2);
    saw1 = 0;
    @(negedge clka);
    if (req_ready[1]) saw1 = 1;
    waitCycle();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clka);
      if (req_ready[1]) saw1 = 1;
      waitCycle();
    end
    checkOutput("withdrawn_never", saw1, 0);

    // Directed arbitration table.
    reset = 1'b1;
    repeat (2) waitCycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 12'((i + 1) * 256), 4'd1);
    for (int i = 0; i < 9; i++) begin
      req_valid = vecs[i].valid;
      @(negedge clka);
      checkOutput($sformatf("vec%0d_ready", i), req_ready, vecs[i].ready);
      checkOutput($sformatf("vec%0d_ena", i), rom_ena, vecs[i].ready != 4'b0000);
      checkOutput($sformatf("vec%0d_addr", i), rom_addra, vecs[i].addr);
      waitCycle();
    end
    req_valid = '0;
    repeat (2) waitCycle();

    // Randomized traffic; the model checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clka);
      rdy = req_ready;
      waitCycle();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && rdy[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 9) == 0) addr_a[i] = 12'($urandom);
        else if (!req_valid[i] && $urandom_range(0, 3) == 0)
          applyStimulus(i, 1'b1, 12'($urandom), 4'($urandom));
      end
    end

    req_valid = '0;
    reset = 1'b0;
    repeat (20) waitCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
